// File: rtl/ex_recv_pkg.sv
// rtl/ex_recv_pkg.sv - shared widths, unit enumeration and FIFO entry type for the execute-stage receiver
package ex_recv_pkg;

  localparam int UNIT_W = 3;
  localparam int TAG_W  = 8;
  localparam int OP_W   = 4;

  // Execution units known to the issue decode. The unit field itself stays a
  // plain vector so that out-of-range indices from decode can be carried and
  // rejected at issue time.
  typedef enum logic [UNIT_W-1:0] {
    UNIT_ALU = 3'd0,
    UNIT_MUL = 3'd1,
    UNIT_LSU = 3'd2,
    UNIT_BRU = 3'd3
  } unit_e;

  typedef struct packed {
    logic [UNIT_W-1:0] unit;
    logic [31:0]       val;
    logic [TAG_W-1:0]  tag;
    logic [OP_W-1:0]   op;
    logic [TAG_W-1:0]  target;
  } ex_entry_t;

endpackage

// File: rtl/ex_recv_if.sv
// rtl/ex_recv_if.sv - ID/EX pipeline register bundle seen by the execute stage
//
// Fields: ce (toggles once per transferred instruction), unit, val, tag, op,
// target. Modport id drives the bundle, modport ex receives it.
interface idex_ex_inf;
  import ex_recv_pkg::*;

  logic              ce;
  logic [UNIT_W-1:0] unit;
  logic [31:0]       val;
  logic [TAG_W-1:0]  tag;
  logic [OP_W-1:0]   op;
  logic [TAG_W-1:0]  target;

  modport id (output ce, unit, val, tag, op, target);
  modport ex (input  ce, unit, val, tag, op, target);

endinterface

// File: rtl/ex_fifo.sv
// rtl/ex_fifo.sv - synchronous FIFO of ex_entry_t with separate occupancy count
//
// Ports: clk, rst (async active-low); push/wr_data write an entry; pop retires
// the head; rd_data is the head (valid while !empty); full, empty, count.
// A push while full is accepted only when a pop happens in the same cycle.
module ex_fifo
  import ex_recv_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  ex_entry_t              wr_data,
  input  logic                   pop,
  output ex_entry_t              rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  ex_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rd_data = mem[rd_ptr];

  // Storage needs no reset: entries are only visible through count.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (do_push && !do_pop) begin
        count <= count + CNT_W'(1);
      end else if (do_pop && !do_push) begin
        count <= count - CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/ex_recv.sv
// rtl/ex_recv.sv - execute-stage receiver: ce toggle detect, FIFO capture, per-unit issue
//
// Ports: clk, rst (async active-low); from_idex (ID/EX bundle, ex modport);
// iss_valid/iss_ready per-unit handshake with shared payload iss_val, iss_tag,
// iss_op, iss_target; fifo_count occupancy; overflow sticky drop flag cleared
// by clr_ovf; err_unit pulses when a head with an illegal unit is discarded.
module ex_recv
  import ex_recv_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int NUM_UNITS = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  idex_ex_inf.ex                 from_idex,
  output logic [NUM_UNITS-1:0]   iss_valid,
  input  logic [NUM_UNITS-1:0]   iss_ready,
  output logic [31:0]            iss_val,
  output logic [TAG_W-1:0]       iss_tag,
  output logic [OP_W-1:0]        iss_op,
  output logic [TAG_W-1:0]       iss_target,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   overflow,
  output logic                   err_unit,
  input  logic                   clr_ovf
);

  logic      ce_seen;
  logic      armed;
  logic      new_instr;
  logic      push;
  logic      pop;
  logic      full;
  logic      empty;
  logic      head_legal;
  logic      head_ready;
  logic      ovf_set;
  ex_entry_t wr_entry;
  ex_entry_t head;

  // The ID/EX register's ce is not reset, so the first sampled level after
  // reset is only a reference point and never counts as an instruction.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ce_seen <= 1'b0;
      armed   <= 1'b0;
    end else begin
      ce_seen <= from_idex.ce;
      armed   <= 1'b1;
    end
  end

  assign new_instr = armed && (from_idex.ce != ce_seen);

  always_comb begin
    wr_entry        = '0;
    wr_entry.unit   = from_idex.unit;
    wr_entry.val    = from_idex.val;
    wr_entry.tag    = from_idex.tag;
    wr_entry.op     = from_idex.op;
    wr_entry.target = from_idex.target;
  end

  ex_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .wr_data (wr_entry),
    .pop     (pop),
    .rd_data (head),
    .full    (full),
    .empty   (empty),
    .count   (fifo_count)
  );

  // Issue decode: iss_valid comes only from the head entry, never from
  // iss_ready. Only the addressed unit's ready bit can retire the head.
  always_comb begin
    iss_valid  = '0;
    head_legal = 1'b0;
    head_ready = 1'b0;
    for (int i = 0; i < NUM_UNITS; i++) begin
      if (!empty && (int'(head.unit) == i)) begin
        iss_valid[i] = 1'b1;
        head_legal   = 1'b1;
        head_ready   = iss_ready[i];
      end
    end
  end

  // An illegal head cannot be offered anywhere, so it is dropped at once.
  assign pop      = !empty && (head_legal ? head_ready : 1'b1);
  assign err_unit = !empty && !head_legal;

  assign push     = new_instr && (!full || pop);
  assign ovf_set  = new_instr && full && !pop;

  assign iss_val    = head.val;
  assign iss_tag    = head.tag;
  assign iss_op     = head.op;
  assign iss_target = head.target;

  // A drop in the same cycle as a clear must remain visible.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow <= 1'b0;
    end else if (ovf_set) begin
      overflow <= 1'b1;
    end else if (clr_ovf) begin
      overflow <= 1'b0;
    end
  end

endmodule
